// File: rtl/lock_guard_ctrl_pkg.sv
// Shared definitions for the door lock guard: FSM state encoding and
// active-low 7-segment patterns (segment order g..a, bit 0 = segment a).
package lock_guard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } lock_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/lock_guard_ctrl_seg7_dec.sv
// seg7_dec: combinational 4-bit digit to active-low 7-segment decoder.
// Ports: digit_i (0..9), blank_i (1 = all segments off), seg_o.
module seg7_dec
    import lock_guard_ctrl_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/lock_guard_ctrl.sv
// lock_guard_ctrl: unlock window, failure counter and timed lockout fed by the
// password FSM status levels; remaining seconds shown on two 7-seg digits.
// Ports: clk, rst (async, active-low), pass_ok_i, pass_err_i, unlock_o,
// lockout_o, fail_cnt_o[3:0], sec_left_o[6:0], hex_tens_o, hex_units_o,
// buzzer_o (only when LOCK_BUZZER_EN is defined: toggles per tick in lockout).
module lock_guard_ctrl
    import lock_guard_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int OPEN_SEC  = 5,
    parameter int LOCK_SEC  = 30,
    parameter int MAX_FAILS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pass_ok_i,
    input  logic       pass_err_i,
    output logic       unlock_o,
    output logic       lockout_o,
    output logic [3:0] fail_cnt_o,
    output logic [6:0] sec_left_o,
    output logic [6:0] hex_tens_o,
    output logic [6:0] hex_units_o
`ifdef LOCK_BUZZER_EN
    ,
    output logic       buzzer_o
`endif
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

    lock_state_e   state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          prev_ok_q, prev_err_q;
    logic          unlock_q, unlock_d;
    logic          lockout_q, lockout_d;
    logic [3:0]    fail_q, fail_d;
    logic [6:0]    sec_q, sec_d;
    logic          presc_clr;
    logic          tick;
    logic          ok_edge, err_edge;

    assign ok_edge  = pass_ok_i & ~prev_ok_q;
    assign err_edge = pass_err_i & ~prev_err_q;
    assign tick     = (presc_q == PRESC_TOP);

    always_comb begin
        state_d   = state_q;
        unlock_d  = unlock_q;
        lockout_d = lockout_q;
        fail_d    = fail_q;
        sec_d     = sec_q;
        presc_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // err takes priority over a simultaneous ok
                if (err_edge) begin
                    if (fail_q + 4'd1 == 4'(MAX_FAILS)) begin
                        state_d   = ST_LOCKOUT;
                        sec_d     = 7'(LOCK_SEC);
                        fail_d    = 4'd0;
                        lockout_d = 1'b1;
                        presc_clr = 1'b1;
                    end else begin
                        fail_d = fail_q + 4'd1;
                    end
                end else if (ok_edge) begin
                    state_d   = ST_OPEN;
                    sec_d     = 7'(OPEN_SEC);
                    fail_d    = 4'd0;
                    unlock_d  = 1'b1;
                    presc_clr = 1'b1;
                end
            end
            ST_OPEN, ST_LOCKOUT: begin
                if (tick) begin
                    if (sec_q == 7'd1) begin
                        state_d   = ST_IDLE;
                        sec_d     = 7'd0;
                        unlock_d  = 1'b0;
                        lockout_d = 1'b0;
                    end else begin
                        sec_d = sec_q - 7'd1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                sec_d     = 7'd0;
                unlock_d  = 1'b0;
                lockout_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (presc_clr || tick) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            prev_ok_q  <= 1'b0;
            prev_err_q <= 1'b0;
            unlock_q   <= 1'b0;
            lockout_q  <= 1'b0;
            fail_q     <= 4'd0;
            sec_q      <= 7'd0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            prev_ok_q  <= pass_ok_i;
            prev_err_q <= pass_err_i;
            unlock_q   <= unlock_d;
            lockout_q  <= lockout_d;
            fail_q     <= fail_d;
            sec_q      <= sec_d;
        end
    end

`ifdef LOCK_BUZZER_EN
    logic buzz_q, buzz_d;

    // Stays 0 on the entry cycle and drops to 0 as lockout ends
    always_comb begin
        buzz_d = 1'b0;
        if (state_q == ST_LOCKOUT && state_d == ST_LOCKOUT) begin
            buzz_d = tick ? ~buzz_q : buzz_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buzz_q <= 1'b0;
        end else begin
            buzz_q <= buzz_d;
        end
    end

    assign buzzer_o = buzz_q;
`endif

    logic blank;
    assign blank = (state_q == ST_IDLE);

    seg7_dec u_tens (
        .digit_i (4'(sec_q / 7'd10)),
        .blank_i (blank),
        .seg_o   (hex_tens_o)
    );

    seg7_dec u_units (
        .digit_i (4'(sec_q % 7'd10)),
        .blank_i (blank),
        .seg_o   (hex_units_o)
    );

    assign unlock_o   = unlock_q;
    assign lockout_o  = lockout_q;
    assign fail_cnt_o = fail_q;
    assign sec_left_o = sec_q;

endmodule

// File: tb/tb_lock_guard_ctrl.sv
// Scoreboard bench for lock_guard_ctrl (TICK_DIV=4, OPEN_SEC=3, LOCK_SEC=5,
// MAX_FAILS=3); stimulus queues expected states, a negedge monitor checks them.
module tb_lock_guard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pass_ok = 1'b0;
    logic       pass_err = 1'b0;
    logic       unlock, lockout;
    logic [3:0] fail_cnt;
    logic [6:0] sec_left, hex_t, hex_u;
`ifdef LOCK_BUZZER_EN
    logic       buzzer;
`endif

    lock_guard_ctrl #(
        .TICK_DIV  (4),
        .OPEN_SEC  (3),
        .LOCK_SEC  (5),
        .MAX_FAILS (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pass_ok_i   (pass_ok),
        .pass_err_i  (pass_err),
        .unlock_o    (unlock),
        .lockout_o   (lockout),
        .fail_cnt_o  (fail_cnt),
        .sec_left_o  (sec_left),
        .hex_tens_o  (hex_t),
        .hex_units_o (hex_u)
`ifdef LOCK_BUZZER_EN
        ,
        .buzzer_o    (buzzer)
`endif
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int         cyc;
        logic       u;
        logic       l;
        logic [3:0] f;
        logic [6:0] s;
        logic       b;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic push(input int dc, input logic u, input logic l,
                        input logic [3:0] f, input logic [6:0] s,
                        input logic b, input string nm);
        exp_t e;
        e.cyc = cycle + dc;
        e.u = u; e.l = l; e.f = f; e.s = s; e.b = b; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic err_pulse();
        pass_err = 1'b1;
        step(1);
        pass_err = 1'b0;
        step(1);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cycle) begin
            exp_t e;
            logic [6:0] et, eu;
            e = sb.pop_front();
            n_run++;
            if (e.cyc < cycle) begin
                n_fail++;
                $display("FAIL %s: check slot cycle %0d passed, now %0d",
                         e.name, e.cyc, cycle);
            end else begin
                if (!e.u && !e.l) begin
                    et = 7'h7F;
                    eu = 7'h7F;
                end else begin
                    et = seg(int'(e.s) / 10);
                    eu = seg(int'(e.s) % 10);
                end
                if ({unlock, lockout, fail_cnt, sec_left, hex_t, hex_u} !==
                    {e.u, e.l, e.f, e.s, et, eu}) begin
                    n_fail++;
                    $display("FAIL %s: got u=%0b l=%0b f=%0d s=%0d ht=%h hu=%h, expected u=%0b l=%0b f=%0d s=%0d ht=%h hu=%h",
                             e.name, unlock, lockout, fail_cnt, sec_left,
                             hex_t, hex_u, e.u, e.l, e.f, e.s, et, eu);
                end
`ifdef LOCK_BUZZER_EN
                n_run++;
                if (buzzer !== e.b) begin
                    n_fail++;
                    $display("FAIL %s_buzz: got %0b, expected %0b",
                             e.name, buzzer, e.b);
                end
`endif
            end
        end
    end

    initial begin
        // reset state
        step(1);
        push(0, 0, 0, 4'd0, 7'd0, 0, "reset");
        step(1);
        rst = 1'b1;
        step(1);

        // unlock window; err during OPEN ignored; no re-open while ok held
        pass_ok = 1'b1;
        push(1, 1, 0, 4'd0, 7'd3, 0, "open_start");
        push(4, 1, 0, 4'd0, 7'd3, 0, "open_pre_tick");
        push(5, 1, 0, 4'd0, 7'd2, 0, "open_sec2");
        step(6);
        pass_err = 1'b1;
        push(1, 1, 0, 4'd0, 7'd2, 0, "open_ign_err");
        push(3, 1, 0, 4'd0, 7'd1, 0, "open_sec1");
        step(1);
        pass_err = 1'b0;
        push(5, 1, 0, 4'd0, 7'd1, 0, "open_last");
        push(6, 0, 0, 4'd0, 7'd0, 0, "open_close");
        push(13, 0, 0, 4'd0, 7'd0, 0, "open_no_reopen");
        step(14);
        pass_ok = 1'b0;
        step(2);

        // three failures -> lockout, countdown, exit
        push(1, 0, 0, 4'd1, 7'd0, 0, "fail1");
        err_pulse();
        push(1, 0, 0, 4'd2, 7'd0, 0, "fail2");
        err_pulse();
        push(1, 0, 1, 4'd0, 7'd5, 0, "lock_enter");
        push(5, 0, 1, 4'd0, 7'd4, 1, "lock_sec4");
        push(13, 0, 1, 4'd0, 7'd2, 1, "lock_sec2");
        push(20, 0, 1, 4'd0, 7'd1, 0, "lock_last");
        push(21, 0, 0, 4'd0, 7'd0, 0, "lock_exit");
        err_pulse();
        err_pulse();
        step(18);

        // ok after two failures clears the count
        push(1, 0, 0, 4'd1, 7'd0, 0, "cnt1");
        err_pulse();
        push(1, 0, 0, 4'd2, 7'd0, 0, "cnt2");
        err_pulse();
        pass_ok = 1'b1;
        push(1, 1, 0, 4'd0, 7'd3, 0, "cnt_clear_open");
        push(13, 0, 0, 4'd0, 7'd0, 0, "cnt_open_done");
        step(14);
        pass_ok = 1'b0;
        step(1);

        // simultaneous ok and err: err wins
        pass_ok  = 1'b1;
        pass_err = 1'b1;
        push(1, 0, 0, 4'd1, 7'd0, 0, "simul");
        push(2, 0, 0, 4'd1, 7'd0, 0, "simul_hold");
        step(2);
        pass_ok  = 1'b0;
        pass_err = 1'b0;
        step(1);

        // async reset in the middle of a lockout
        push(1, 0, 0, 4'd2, 7'd0, 0, "pre_lock");
        err_pulse();
        push(1, 0, 1, 4'd0, 7'd5, 0, "lock2");
        err_pulse();
        step(5);
        rst = 1'b0;
        push(0, 0, 0, 4'd0, 7'd0, 0, "rst_async");
        step(2);
        push(0, 0, 0, 4'd0, 7'd0, 0, "rst_hold");
        rst = 1'b1;
        push(1, 0, 0, 4'd0, 7'd0, 0, "post_rst");
        step(1);
        pass_ok = 1'b1;
        push(1, 1, 0, 4'd0, 7'd3, 0, "post_rst_open");
        step(2);
        pass_ok = 1'b0;

        for (int i = 0; i < 100 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            n_run++;
            n_fail++;
            $display("FAIL drain: %0d checks left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
